// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - MIPS execute stage with forwarding, ALU, registered EX/MEM output and iterative multiplier
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   flush                 kills ID/EX, multiplier progress and the output register
//   id_*                  instruction fields and operands presented by ID
//   mem_*, wb_*           destination, RegWrite and value of the MEM and WB stages
//   stall_out             combinational hold request to ID/IF while a multiply runs
//   ex_*                  registered EX/MEM outputs
module ex_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int FWD_EN = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [1:0]      id_wb,
    input  logic [2:0]      id_m,
    input  logic [3:0]      id_ex,
    input  logic            id_mdu,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_data_a,
    input  logic [XLEN-1:0] id_data_b,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] mem_rd,
    input  logic [REGW-1:0] wb_rd,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] mem_alu_out,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_out,
    output logic            ex_valid,
    output logic [1:0]      ex_wb,
    output logic [2:0]      ex_m,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_dest,
    output logic            ex_zero
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // ID/EX pipeline register
    logic            idex_valid;
    logic [1:0]      idex_wb;
    logic [2:0]      idex_m;
    logic [3:0]      idex_ex;
    logic            idex_mdu;
    logic [REGW-1:0] idex_rs;
    logic [REGW-1:0] idex_rt;
    logic [REGW-1:0] idex_rd;
    logic [XLEN-1:0] idex_a;
    logic [XLEN-1:0] idex_b;
    logic [XLEN-1:0] idex_imm;

    // multiplier datapath
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] out_res;
    logic            mdu_start;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idex_valid <= 1'b0;
            idex_wb    <= '0;
            idex_m     <= '0;
            idex_ex    <= '0;
            idex_mdu   <= 1'b0;
            idex_rs    <= '0;
            idex_rt    <= '0;
            idex_rd    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
        end else if (flush) begin
            idex_valid <= 1'b0;
            idex_wb    <= '0;
            idex_m     <= '0;
            idex_mdu   <= 1'b0;
        end else if (!stall_out) begin
            idex_valid <= id_valid;
            idex_wb    <= id_valid ? id_wb : 2'b00;
            idex_m     <= id_valid ? id_m : 3'b000;
            idex_mdu   <= id_valid & id_mdu;
            idex_ex    <= id_ex;
            idex_rs    <= id_rs;
            idex_rt    <= id_rt;
            idex_rd    <= id_rd;
            idex_a     <= id_data_a;
            idex_b     <= id_data_b;
            idex_imm   <= id_imm;
        end
    end

    // Forwarding: MEM is the younger producer so it wins over WB; r0 never forwards.
    always_comb begin
        fwd_a = idex_a;
        fwd_b = idex_b;
        if (FWD_EN != 0) begin
            if (mem_regwrite && (mem_rd == idex_rs) && (mem_rd != '0)) begin
                fwd_a = mem_alu_out;
            end else if (wb_regwrite && (wb_rd == idex_rs) && (wb_rd != '0)) begin
                fwd_a = wb_data;
            end
            if (mem_regwrite && (mem_rd == idex_rt) && (mem_rd != '0)) begin
                fwd_b = mem_alu_out;
            end else if (wb_regwrite && (wb_rd == idex_rt) && (wb_rd != '0)) begin
                fwd_b = wb_data;
            end
        end
    end

    always_comb begin
        alu_b   = idex_ex[2] ? idex_imm : fwd_b;
        alu_res = '0;
        case (idex_ex[1:0])
            2'b00: alu_res = fwd_a + alu_b;
            2'b01: alu_res = fwd_a - alu_b;
            2'b10: begin
                case (idex_imm[5:0])
                    6'h20:   alu_res = fwd_a + alu_b;
                    6'h22:   alu_res = fwd_a - alu_b;
                    6'h24:   alu_res = fwd_a & alu_b;
                    6'h25:   alu_res = fwd_a | alu_b;
                    6'h27:   alu_res = ~(fwd_a | alu_b);
                    6'h2A:   alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    assign mdu_start = idex_valid & idex_mdu;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mdu_start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == CW'(XLEN - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
        // Dropping the stall during flush lets ID advance on the same edge the op is killed.
        stall_out = reset_n & mdu_start & (state != S_DONE) & ~flush;
    end

    // Operands are captured only on IDLE->BUSY, so later forwarding changes cannot corrupt them.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            state <= state_nxt;
            if (!flush) begin
                if (state == S_IDLE && mdu_start) begin
                    mcand  <= fwd_a;
                    mplier <= fwd_b;
                    acc    <= '0;
                    cnt    <= '0;
                end else if (state == S_BUSY) begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end

    assign out_res = idex_mdu ? acc : alu_res;

    // MDU ops only reach EX/MEM in the DONE cycle; every other cycle of the op is a bubble.
    always_ff @(posedge clock) begin
        if (!reset_n || flush || !idex_valid || (idex_mdu && state != S_DONE)) begin
            ex_valid      <= 1'b0;
            ex_wb         <= '0;
            ex_m          <= '0;
            ex_result     <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            ex_zero       <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_wb         <= idex_wb;
            ex_m          <= idex_m;
            ex_result     <= out_res;
            ex_store_data <= fwd_b;
            ex_dest       <= idex_ex[3] ? idex_rd : idex_rt;
            ex_zero       <= (out_res == '0);
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - directed-vector bench for ex_stage_mdu
module tb_ex_stage_mdu;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [3:0]  id_ex;
    logic        id_mdu;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_data_a, id_data_b, id_imm;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_alu_out, wb_data;
    logic        stall_out;
    logic        ex_valid;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_zero;

    int nvec = 0;
    int nmis = 0;

    ex_stage_mdu #(.XLEN(32), .REGW(5), .FWD_EN(1)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .id_valid(id_valid), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_mdu(id_mdu),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_data_a(id_data_a), .id_data_b(id_data_b), .id_imm(id_imm),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_alu_out(mem_alu_out), .wb_data(wb_data),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_wb(ex_wb), .ex_m(ex_m),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_zero(ex_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        if (obs !== expv) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] ex, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_valid = 1'b1; id_mdu = 1'b0; id_wb = 2'b01; id_m = 3'b010; id_ex = ex;
        id_data_a = a; id_data_b = b; id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
        step();
        id_valid = 1'b0;
        step();
    endtask

    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
        int cnt;
        logic bad;
        id_valid = 1'b1; id_mdu = 1'b1; id_ex = 4'b1000; id_wb = 2'b01; id_m = 3'b000;
        id_data_a = a; id_data_b = b; id_imm = 32'h0; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7;
        step();
        // follow-up ADD held in ID while the multiply stalls
        id_mdu = 1'b0; id_ex = 4'b1010; id_data_a = 32'd1; id_data_b = 32'd2;
        id_imm = 32'h20; id_rd = 5'd8;
        cnt = 0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!stall_out) break;
            cnt++;
            if (ex_valid) bad = 1'b1;
            step();
        end
        check({tag, " stall cycles"}, 64'(cnt), 64'd33);
        check({tag, " valid in stall"}, 64'(bad), 64'd0);
        step();
        check({tag, " valid"}, 64'(ex_valid), 64'd1);
        check({tag, " result"}, 64'(ex_result), 64'(expv));
        check({tag, " dest"}, 64'(ex_dest), 64'd7);
        id_valid = 1'b0;
        step();
        check({tag, " next add"}, 64'(ex_result), 64'd3);
        check({tag, " next dest"}, 64'(ex_dest), 64'd8);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_wb = 2'b01; id_m = 3'b010; id_ex = 4'b1010; id_mdu = 1'b0;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd10;
        id_data_a = 32'd5; id_data_b = 32'd7; id_imm = 32'h20;
        mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_alu_out = 32'h0; wb_data = 32'h0;

        step();
        step();
        check("rst ex_valid", 64'(ex_valid), 64'd0);
        check("rst ex_result", 64'(ex_result), 64'd0);
        check("rst ex_wb", 64'(ex_wb), 64'd0);
        check("rst ex_m", 64'(ex_m), 64'd0);
        check("rst ex_dest", 64'(ex_dest), 64'd0);
        check("rst ex_zero", 64'(ex_zero), 64'd0);
        check("rst stall", 64'(stall_out), 64'd0);

        reset_n = 1'b1;
        step();
        check("post-rst cycle1 valid", 64'(ex_valid), 64'd0);
        id_valid = 1'b0;
        step();
        check("post-rst add valid", 64'(ex_valid), 64'd1);
        check("add 5+7", 64'(ex_result), 64'd12);
        check("add zero", 64'(ex_zero), 64'd0);
        check("add dest rd", 64'(ex_dest), 64'd10);
        check("add wb", 64'(ex_wb), 64'd1);
        check("add m", 64'(ex_m), 64'd2);
        step();
        check("bubble valid", 64'(ex_valid), 64'd0);
        check("bubble wb", 64'(ex_wb), 64'd0);

        alu_op(4'b0001, 32'd9, 32'd9, 32'h0, 5'd1, 5'd2, 5'd10);
        check("sub 9-9", 64'(ex_result), 64'd0);
        check("sub zero", 64'(ex_zero), 64'd1);
        check("sub dest rt", 64'(ex_dest), 64'd2);

        // forwarding priority
        mem_rd = 5'd3; mem_alu_out = 32'hAA; mem_regwrite = 1'b1;
        wb_rd = 5'd3; wb_data = 32'hBB; wb_regwrite = 1'b1;
        alu_op(4'b0000, 32'h11, 32'd1, 32'h0, 5'd3, 5'd2, 5'd10);
        check("fwd mem prio", 64'(ex_result), 64'hAB);
        mem_regwrite = 1'b0;
        alu_op(4'b0000, 32'h11, 32'd1, 32'h0, 5'd3, 5'd2, 5'd10);
        check("fwd wb", 64'(ex_result), 64'hBC);
        mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        alu_op(4'b0000, 32'h11, 32'd1, 32'h0, 5'd0, 5'd2, 5'd10);
        check("fwd r0 none", 64'(ex_result), 64'h12);
        mem_regwrite = 1'b0;
        wb_rd = 5'd4; wb_data = 32'h55;
        alu_op(4'b0100, 32'h10, 32'h99, 32'd3, 5'd1, 5'd4, 5'd10);
        check("imm add", 64'(ex_result), 64'h13);
        check("store fwd b", 64'(ex_store_data), 64'h55);
        wb_regwrite = 1'b0; wb_rd = 5'd0;

        // funct decode
        alu_op(4'b1010, 32'hF0F0, 32'h0FF0, 32'h24, 5'd1, 5'd2, 5'd10);
        check("and", 64'(ex_result), 64'h00F0);
        alu_op(4'b1010, 32'hF0F0, 32'h0FF0, 32'h25, 5'd1, 5'd2, 5'd10);
        check("or", 64'(ex_result), 64'hFFF0);
        alu_op(4'b1010, 32'hF0F0, 32'h0FF0, 32'h27, 5'd1, 5'd2, 5'd10);
        check("nor", 64'(ex_result), 64'hFFFF000F);
        alu_op(4'b1010, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 5'd10);
        check("slt -1<1", 64'(ex_result), 64'd1);
        alu_op(4'b1010, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd2, 5'd10);
        check("slt 1<-1", 64'(ex_result), 64'd0);
        alu_op(4'b1010, 32'd6, 32'd4, 32'h22, 5'd1, 5'd2, 5'd10);
        check("funct sub", 64'(ex_result), 64'd2);
        alu_op(4'b1010, 32'd6, 32'd4, 32'h03, 5'd1, 5'd2, 5'd10);
        check("undef funct", 64'(ex_result), 64'd0);
        alu_op(4'b0011, 32'd6, 32'd4, 32'h20, 5'd1, 5'd2, 5'd10);
        check("aluop 11", 64'(ex_result), 64'd0);
        alu_op(4'b0000, 32'h7FFFFFFF, 32'd1, 32'h0, 5'd1, 5'd2, 5'd10);
        check("overflow add", 64'(ex_result), 64'h80000000);
        check("overflow valid", 64'(ex_valid), 64'd1);

        do_mul("mul ffff", 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF);
        do_mul("mul zero", 32'h00001234, 32'h0, 32'h0);

        // flush in the middle of a multiply
        id_valid = 1'b1; id_mdu = 1'b1; id_ex = 4'b1000;
        id_data_a = 32'd3; id_data_b = 32'd5; id_rd = 5'd7;
        step();
        id_valid = 1'b0; id_mdu = 1'b0;
        check("flush pre stall", 64'(stall_out), 64'd1);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        check("flush stall same cycle", 64'(stall_out), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush stall next", 64'(stall_out), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ex_valid || stall_out) seen = 1'b1;
            step();
        end
        check("flush no result", 64'(seen), 64'd0);
        alu_op(4'b1010, 32'd20, 32'd22, 32'h20, 5'd1, 5'd2, 5'd11);
        check("post-flush add", 64'(ex_result), 64'd42);
        check("post-flush dest", 64'(ex_dest), 64'd11);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
Parametrised next-generation execute stage for the 5-stage MIPS pipeline. It contains:
- the ID/EX pipeline register;
- MEM/WB forwarding with priority;
- the ALU and ALU control;
- a registered EX/MEM output;
- an iterative shift-add multiply unit (MDU) that stalls the front end while it runs.

Unlike the previous EX stage, the datapath width is parametrised, outputs are registered, and multi-cycle ops and flush are supported.

Parameters:
XLEN, 32, datapath width in bits (8..64).
REGW, 5, register index width.
FWD_EN, 1, 1 = forwarding enabled; 0 = forward selects tied to register-file values.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
flush  input  1  synchronous kill of ID/EX, MDU and output register contents
id_valid  input  1  ID presents a valid instruction
id_wb  input  2  WB control; bit0 = RegWrite
id_m  input  3  MEM control
id_ex  input  4  [3] RegDst, [2] ALUSrc, [1:0] ALUOp
id_mdu  input  1  instruction is MUL (low XLEN bits of product)
id_rs, id_rt, id_rd  input  REGW  register indices
id_data_a, id_data_b, id_imm  input  XLEN  rs value, rt value, sign-extended immediate
mem_rd, wb_rd  input  REGW  destinations in MEM and WB
mem_regwrite, wb_regwrite  input  1  RegWrite of MEM and WB
mem_alu_out, wb_data  input  XLEN  forwardable values
stall_out  output  1  ID/IF must hold; combinational
ex_valid  output  1  ex_* carry a real instruction
ex_wb  output  2  registered WB control
ex_m  output  3  registered MEM control
ex_result  output  XLEN  ALU/MDU result
ex_store_data  output  XLEN  forwarded rt value
ex_dest  output  REGW  destination register
ex_zero  output  1  ex_result == 0

Behaviour:
Reset (reset_n=0 at a clock edge):
- ID/EX valid=0; FSM=IDLE; counter=0.
- All ex_* outputs = 0; stall_out = 0.
- Reset mid-multiply aborts the op with no result.

ID/EX register:
- Loads id_* when !stall_out.
- id_valid=0 or flush loads a bubble: valid=0, wb=00, m=000.
- Holds its contents while stall_out=1.

Forwarding (operand A from rs, operand B from rt):
- Select MEM value if mem_regwrite & mem_rd==rs/rt & mem_rd!=0.
- Else select WB value if wb_regwrite & wb_rd==rs/rt & wb_rd!=0.
- Else use the register-file value.
- MEM has priority when both stages match.
- ALU B input = ALUSrc ? imm : forwarded B.
- ex_store_data = forwarded B, never the immediate.

ALU:
- ALUOp 00 = add; 01 = sub; 10 = decode by imm[5:0].
- imm[5:0] decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0 zero-extended).
- Undefined funct or ALUOp 11 gives result 0.
- Arithmetic wraps modulo 2^XLEN; no overflow trap.
- ex_dest = RegDst ? rd : rt.

Output register:
- Non-MDU instruction in ID/EX: loads on the next edge. Latency is 1 cycle from ID/EX, 2 cycles from acceptance at ID.
- Bubble or stalled cycle: loads a bubble (ex_valid=0, wb=00, m=000).

MDU FSM:
- IDLE: if ID/EX holds a valid MDU op, capture the forwarded A/B into the multiplicand/multiplier, clear the accumulator, go to BUSY.
- BUSY: one shift-add step per cycle for XLEN cycles, then go to DONE.
- DONE: lasts one cycle; the output register loads accumulator[XLEN-1:0]; return to IDLE.
- stall_out = ID/EX valid & id_mdu & state!=DONE.
- Op in ID/EX at cycle T: stall_out high for cycles T..T+XLEN (XLEN+1 cycles), result visible at T+XLEN+2, next instruction enters ID/EX at the DONE edge.
- Operands are captured only at IDLE->BUSY, so MEM/WB draining during the stall does not corrupt them.
- Back-to-back MDU ops: the second op starts from IDLE on the cycle after DONE.

Flush:
- Has priority over stall and MDU progress: FSM->IDLE, stall_out drops the same cycle, the MDU result is discarded.
- flush together with reset_n=0: reset wins.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with id_valid=1 -> all ex_* = 0, stall_out = 0; first instruction appears 2 cycles after release.
- ADD with ALUOp=10, funct 0x20, A=5, B=7 -> ex_result=12, ex_zero=0, ex_dest=rd; ALUOp=01 with A=B=9 -> ex_result=0, ex_zero=1.
- Forward priority: rs=3, mem_rd=3 (mem_alu_out=0xAA), wb_rd=3 (wb_data=0xBB), both RegWrite=1 -> MEM value 0xAA used; rs=0 with mem_rd=0 -> register-file value used.
- MUL with XLEN=32, A=0xFFFF, B=0x10001 -> stall_out high exactly 33 cycles, ex_valid=0 during the stall, then ex_result=0xFFFFFFFF; also check B=0 gives 0.
- Flush at BUSY cycle 10 -> stall_out low next cycle, no MDU result ever emitted, the following ADD completes normally.
- slt with A=0xFFFFFFFF (-1), B=1 -> 1; overflow add 0x7FFFFFFF+1 -> 0x80000000 with no trap.
